vx_warp_sched_mc: RTL and testbench
===================================

Name: vx_warp_sched_mc

Overview:
- Multi-channel warp scheduler; successor to the single-issue core scheduler.
- Warps are partitioned into ISSUE_WIDTH channels by wid % ISSUE_WIDTH.
- Each channel picks one ready warp per cycle, using a round-robin or fixed-priority policy, and presents {wid, tmask, PC} on a registered valid/ready output to fetch.
- Sits between warp-control/branch/decode feedback and the fetch stage.

Parameters:
NUM_WARPS, 8, total warps; power of 2, >= ISSUE_WIDTH
NUM_THREADS, 4, threads per warp
PC_BITS, 30, PC width (word-granular; one instruction = +1)
ISSUE_WIDTH, 2, scheduling channels; power of 2; divides NUM_WARPS
NUM_BARRIERS, 4, local barrier slots
RR_POLICY, 1, 1 = round-robin per channel; 0 = lowest-index-first

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
startup_pc  in  PC_BITS  warp 0 PC loaded at reset
unlock_valid  in  ISSUE_WIDTH  per-channel decode unlock
unlock_wid  in  ISSUE_WIDTH*log2(NUM_WARPS)  warp unlocked per channel
br_valid  in  ISSUE_WIDTH  per-channel branch resolve
br_wid  in  ISSUE_WIDTH*log2(NUM_WARPS)  branch warp
br_taken  in  ISSUE_WIDTH  taken flag
br_dest  in  ISSUE_WIDTH*PC_BITS  branch target
tmc_valid  in  1  thread-mask change
tmc_wid  in  log2(NUM_WARPS)  target warp
tmc_mask  in  NUM_THREADS  new mask; zero deactivates the warp
bar_valid  in  1  barrier arrival
bar_wid  in  log2(NUM_WARPS)  arriving warp
bar_id  in  log2(NUM_BARRIERS)  barrier slot
bar_size_m1  in  log2(NUM_WARPS)  participants minus 1
out_valid  out  ISSUE_WIDTH  issue valid per channel
out_ready  in  ISSUE_WIDTH  fetch ready per channel
out_wid  out  ISSUE_WIDTH*log2(NUM_WARPS)  issued warp
out_tmask  out  ISSUE_WIDTH*NUM_THREADS  issued thread mask
out_pc  out  ISSUE_WIDTH*PC_BITS  issued PC
active_warps  out  NUM_WARPS  active mask
busy  out  1  registered: any warp active or any out_valid

Behaviour:
- Reset (async assert, sync deassert):
  - warp 0 active, tmask = 1, PC = startup_pc; all other warps inactive with zero PC/tmask.
  - stalled = 0; barrier masks/counters = 0; RR pointers = 0.
  - out_valid = 0, out_* = 0, busy = 0.
  - Reset mid-operation discards all state, including pending barriers.
- ready = active & ~stalled. Channel c considers only warps with wid % ISSUE_WIDTH == c.
- Selection:
  - RR_POLICY = 1: first ready warp strictly after the channel's last-issued warp, wrapping; the pointer updates only on issue.
  - RR_POLICY = 0: lowest wid.
- Output register per channel:
  - Loads when (~out_valid | out_ready) and a warp is selected.
  - On load: warp stalled; warp PC += 1 (mod 2^PC_BITS); out_pc carries the pre-increment PC.
  - Selection to out_valid latency = 1 cycle; one warp issued per channel per cycle.
  - out_* hold stable while out_valid & ~out_ready.
  - out_valid drops the cycle after acceptance if nothing is selected.
- Feedback updates in next-state, lowest to highest precedence:
  1. Unlock: clear stalled.
  2. TMC: set tmask; active = (mask != 0); clear stalled.
  3. Barrier:
     - If counter[id] == bar_size_m1: release. Clear stalled for mask[id] and bar_wid; reset counter and mask.
     - Otherwise: counter += 1; set mask[id][bar_wid]; the warp stays stalled.
  4. Branch: if taken, PC = dest; clear stalled.
  5. Issue: set stalled; PC increment.
- Simultaneous events:
  - Issue stall overrides any same-cycle unlock of the same warp.
  - Branch taken to a warp being issued that cycle: branch dest wins and is not incremented. This cannot occur legally, because the warp is stalled; it is specified for safety.
- Two channels never target the same warp, because the wid partitions are disjoint.
- A barrier with bar_size_m1 = 0 releases immediately.
- A counter never exceeds bar_size_m1.
- TMC to an inactive warp activates it with its current PC.

Optional Feature:
SCHED_PERF_EN:
- Defined: adds output perf_idles [ISSUE_WIDTH*32], counting per-channel cycles with no ready warp.
- Defined: adds output perf_stalls [ISSUE_WIDTH*32], counting cycles with out_valid & ~out_ready.
- Both counters wrap and reset to 0.
- Undefined: ports and logic are absent; no other behaviour changes.

Test Plan:
- Reset with startup_pc = 0x100, out_ready = 1 -> channel 0 issues wid 0, pc 0x100, tmask 0001 one cycle after reset release; then no reissue until unlock; unlock -> pc 0x101.
- TMC on wid 0 with mask 0 -> active_warps = 0; busy falls the cycle after the last out_valid clears.
- RR_POLICY = 1, ISSUE_WIDTH = 2, warps 0/2/4 active:
  - Always unlocking -> channel 0 issues 0, 2, 4, 0.
  - RR_POLICY = 0 under the same stimulus -> 0, 0, 0.
- Barrier id 1, size_m1 = 2:
  - Warps 1 and 3 arrive -> both remain stalled, counter = 2.
  - Warp 5 arrives -> all three are unstalled the next cycle; counter and mask = 0.
- out_ready held 0 for 5 cycles -> out_pc/out_wid stable; PC is not advanced again; with SCHED_PERF_EN, perf_stalls += 5.
- br_valid taken to dest 0x40 on wid 1 -> next issue of wid 1 carries pc 0x40.

Source files
------------

// File: rtl/vx_warp_sched_mc_if.sv
// ---------------------------------------------------------------------------
// vx_warp_sched_mc_if
//   Issue bus between the multi-channel warp scheduler and fetch.
//   One lane per scheduling channel, packed channel-major
//   (channel c occupies bits [c*W +: W] of each field).
//
//   out_valid  scheduler -> fetch  issue valid per channel
//   out_ready  fetch -> scheduler  fetch ready per channel
//   out_wid    scheduler -> fetch  issued warp id
//   out_tmask  scheduler -> fetch  issued thread mask
//   out_pc     scheduler -> fetch  issued PC (pre-increment)
//
//   master: the scheduler side. slave: the fetch side.
// ---------------------------------------------------------------------------
interface vx_warp_sched_mc_if #(
    parameter int NUM_WARPS   = 8,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 30,
    parameter int ISSUE_WIDTH = 2
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [ISSUE_WIDTH-1:0]             out_valid;
    logic [ISSUE_WIDTH-1:0]             out_ready;
    logic [ISSUE_WIDTH*WID_W-1:0]       out_wid;
    logic [ISSUE_WIDTH*NUM_THREADS-1:0] out_tmask;
    logic [ISSUE_WIDTH*PC_BITS-1:0]     out_pc;

    modport master (
        output out_valid, out_wid, out_tmask, out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_wid, out_tmask, out_pc,
        output out_ready
    );
endinterface

// File: rtl/vx_warp_sched_mc.sv
// ---------------------------------------------------------------------------
// vx_warp_sched_mc
//   Multi-channel warp scheduler. Warps are split into ISSUE_WIDTH channels
//   by wid % ISSUE_WIDTH; each channel picks one ready (active, not stalled)
//   warp per cycle, round-robin (RR_POLICY=1) or lowest-wid-first
//   (RR_POLICY=0), and presents {wid, tmask, pc} on a registered
//   valid/ready lane of the fetch interface.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   startup_pc     PC loaded into warp 0 at reset
//   unlock_*       per-channel decode unlock (clears stall)
//   br_*           per-channel branch resolve (taken -> PC = dest)
//   tmc_*          thread-mask change; zero mask deactivates the warp
//   bar_*          barrier arrival (slot id, participants minus 1)
//   fetch          issue bus (master modport)
//   active_warps   active mask
//   busy           registered: any warp active or any out_valid
//
// Optional feature (macro SCHED_PERF_EN)
//   perf_idles     per-channel count of cycles with no ready warp
//   perf_stalls    per-channel count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module vx_warp_sched_mc #(
    parameter int NUM_WARPS    = 8,
    parameter int NUM_THREADS  = 4,
    parameter int PC_BITS      = 30,
    parameter int ISSUE_WIDTH  = 2,
    parameter int NUM_BARRIERS = 4,
    parameter int RR_POLICY    = 1,
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int BAR_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PC_BITS-1:0]               startup_pc,
    input  logic [ISSUE_WIDTH-1:0]           unlock_valid,
    input  logic [ISSUE_WIDTH*WID_W-1:0]     unlock_wid,
    input  logic [ISSUE_WIDTH-1:0]           br_valid,
    input  logic [ISSUE_WIDTH*WID_W-1:0]     br_wid,
    input  logic [ISSUE_WIDTH-1:0]           br_taken,
    input  logic [ISSUE_WIDTH*PC_BITS-1:0]   br_dest,
    input  logic                             tmc_valid,
    input  logic [WID_W-1:0]                 tmc_wid,
    input  logic [NUM_THREADS-1:0]           tmc_mask,
    input  logic                             bar_valid,
    input  logic [WID_W-1:0]                 bar_wid,
    input  logic [BAR_W-1:0]                 bar_id,
    input  logic [WID_W-1:0]                 bar_size_m1,
    vx_warp_sched_mc_if.master               fetch,
    output logic [NUM_WARPS-1:0]             active_warps,
    output logic                             busy
`ifdef SCHED_PERF_EN
    ,
    output logic [ISSUE_WIDTH*32-1:0]        perf_idles,
    output logic [ISSUE_WIDTH*32-1:0]        perf_stalls
`endif
);
    // Warps per channel and width of a channel-local warp index.
    localparam int WPC = NUM_WARPS / ISSUE_WIDTH;
    localparam int LW  = (WPC > 1) ? $clog2(WPC) : 1;

    // Per-warp state
    logic [NUM_WARPS-1:0]   active_q, active_n;
    logic [NUM_WARPS-1:0]   stalled_q, stalled_n;
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_n [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_q    [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_n    [NUM_WARPS];

    // Barrier slots: participant mask and arrival counter
    logic [NUM_WARPS-1:0]   bar_mask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]   bar_mask_n [NUM_BARRIERS];
    logic [WID_W-1:0]       bar_cnt_q  [NUM_BARRIERS];
    logic [WID_W-1:0]       bar_cnt_n  [NUM_BARRIERS];

    // Per-channel selection and output registers
    logic [LW-1:0]          rr_ptr_q  [ISSUE_WIDTH];
    logic [LW-1:0]          sel_local [ISSUE_WIDTH];
    logic [WID_W-1:0]       sel_wid   [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] sel_valid;
    logic [ISSUE_WIDTH-1:0] fire;

    logic [ISSUE_WIDTH-1:0]                  out_valid_q;
    logic [ISSUE_WIDTH-1:0][WID_W-1:0]       out_wid_q;
    logic [ISSUE_WIDTH-1:0][NUM_THREADS-1:0] out_tmask_q;
    logic [ISSUE_WIDTH-1:0][PC_BITS-1:0]     out_pc_q;

    logic [NUM_WARPS-1:0] ready;
    assign ready = active_q & ~stalled_q;

    // -----------------------------------------------------------------------
    // Per-channel pick. Round-robin scans from the slot after the last issued
    // warp and wraps, so the last-issued warp is the final candidate.
    // -----------------------------------------------------------------------
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a value before any
        // conditional, so no path leaves it unassigned and no latch appears.
        idx       = 0;
        sel_valid = '0;
        fire      = '0;
        for (int c = 0; c < ISSUE_WIDTH; c++) begin
            sel_local[c] = '0;
            sel_wid[c]   = '0;
            for (int k = 0; k < WPC; k++) begin
                if (RR_POLICY != 0) idx = (int'(rr_ptr_q[c]) + 1 + k) % WPC;
                else                idx = k;
                if (!sel_valid[c] && ready[idx*ISSUE_WIDTH + c]) begin
                    sel_valid[c] = 1'b1;
                    sel_local[c] = LW'(idx);
                    sel_wid[c]   = WID_W'(idx*ISSUE_WIDTH + c);
                end
            end
            fire[c] = sel_valid[c] & (~out_valid_q[c] | fetch.out_ready[c]);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state for warp and barrier state. Later steps override earlier
    // ones: unlock < tmc < barrier < branch < issue-stall. A taken branch
    // overwrites the issue PC increment of the same warp.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [WID_W-1:0] w;
        // NOTE: blocking assignments here are deliberate: each feedback step
        // must see the result of the lower-precedence steps before it.
        active_n   = active_q;
        stalled_n  = stalled_q;
        tmask_n    = tmask_q;
        pc_n       = pc_q;
        bar_mask_n = bar_mask_q;
        bar_cnt_n  = bar_cnt_q;
        w          = '0;

        for (int c = 0; c < ISSUE_WIDTH; c++) begin
            if (unlock_valid[c]) stalled_n[unlock_wid[c*WID_W +: WID_W]] = 1'b0;
        end

        if (tmc_valid) begin
            tmask_n[tmc_wid]   = tmc_mask;
            active_n[tmc_wid]  = |tmc_mask;
            stalled_n[tmc_wid] = 1'b0;
        end

        if (bar_valid) begin
            if (bar_cnt_q[bar_id] == bar_size_m1) begin
                // Last participant: release everyone waiting on this slot.
                stalled_n          = stalled_n & ~bar_mask_q[bar_id];
                stalled_n[bar_wid] = 1'b0;
                bar_cnt_n[bar_id]  = '0;
                bar_mask_n[bar_id] = '0;
            end else begin
                bar_cnt_n[bar_id]           = bar_cnt_q[bar_id] + WID_W'(1);
                bar_mask_n[bar_id][bar_wid] = 1'b1;
            end
        end

        for (int c = 0; c < ISSUE_WIDTH; c++) begin
            if (fire[c]) pc_n[sel_wid[c]] = pc_q[sel_wid[c]] + PC_BITS'(1);
        end

        for (int c = 0; c < ISSUE_WIDTH; c++) begin
            if (br_valid[c]) begin
                w = br_wid[c*WID_W +: WID_W];
                if (br_taken[c]) pc_n[w] = br_dest[c*PC_BITS +: PC_BITS];
                stalled_n[w] = 1'b0;
            end
        end

        for (int c = 0; c < ISSUE_WIDTH; c++) begin
            if (fire[c]) stalled_n[sel_wid[c]] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q    <= NUM_WARPS'(1);
            stalled_q   <= '0;
            // NOTE: these arrays are small register files whose reset
            // contents are architecturally visible, so every entry is reset
            // (warp 0 boots at startup_pc; pending barriers are discarded).
            for (int i = 0; i < NUM_WARPS; i++) begin
                tmask_q[i] <= (i == 0) ? NUM_THREADS'(1) : '0;
                pc_q[i]    <= (i == 0) ? startup_pc : '0;
            end
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                bar_mask_q[b] <= '0;
                bar_cnt_q[b]  <= '0;
            end
            for (int c = 0; c < ISSUE_WIDTH; c++) begin
                rr_ptr_q[c] <= '0;
            end
            out_valid_q <= '0;
            out_wid_q   <= '0;
            out_tmask_q <= '0;
            out_pc_q    <= '0;
            busy        <= 1'b0;
        end else begin
            active_q   <= active_n;
            stalled_q  <= stalled_n;
            tmask_q    <= tmask_n;
            pc_q       <= pc_n;
            bar_mask_q <= bar_mask_n;
            bar_cnt_q  <= bar_cnt_n;
            for (int c = 0; c < ISSUE_WIDTH; c++) begin
                if (fire[c]) begin
                    out_valid_q[c] <= 1'b1;
                    out_wid_q[c]   <= sel_wid[c];
                    out_tmask_q[c] <= tmask_q[sel_wid[c]];
                    out_pc_q[c]    <= pc_q[sel_wid[c]];
                    rr_ptr_q[c]    <= sel_local[c];
                end else if (fetch.out_ready[c]) begin
                    out_valid_q[c] <= 1'b0;
                end
            end
            busy <= (|active_q) | (|out_valid_q);
        end
    end

    assign fetch.out_valid = out_valid_q;
    assign fetch.out_wid   = out_wid_q;
    assign fetch.out_tmask = out_tmask_q;
    assign fetch.out_pc    = out_pc_q;
    assign active_warps    = active_q;

`ifdef SCHED_PERF_EN
    logic [ISSUE_WIDTH-1:0][31:0] perf_idles_q;
    logic [ISSUE_WIDTH-1:0][31:0] perf_stalls_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_idles_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            for (int c = 0; c < ISSUE_WIDTH; c++) begin
                if (!sel_valid[c])
                    perf_idles_q[c] <= perf_idles_q[c] + 32'd1;
                if (out_valid_q[c] && !fetch.out_ready[c])
                    perf_stalls_q[c] <= perf_stalls_q[c] + 32'd1;
            end
        end
    end

    assign perf_idles  = perf_idles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_warp_sched_mc.sv
// ---------------------------------------------------------------------------
// tb_vx_warp_sched_mc
//   Two scheduler instances share all feedback stimulus: u_rr uses
//   round-robin selection, u_fp lowest-wid-first. A vector table drives the
//   policy comparison; hand-written sequences cover boot/unlock/TMC,
//   barriers, backpressure, branches and PC wrap.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vx_warp_sched_mc;
    localparam int NW = 8;
    localparam int NT = 4;
    localparam int PB = 30;
    localparam int IW = 2;
    localparam int NB = 4;
    localparam int WW = 3;
    localparam int BW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [PB-1:0]     startup_pc;
    logic [IW-1:0]     unlock_valid;
    logic [IW*WW-1:0]  unlock_wid;
    logic [IW-1:0]     br_valid;
    logic [IW*WW-1:0]  br_wid;
    logic [IW-1:0]     br_taken;
    logic [IW*PB-1:0]  br_dest;
    logic              tmc_valid;
    logic [WW-1:0]     tmc_wid;
    logic [NT-1:0]     tmc_mask;
    logic              bar_valid;
    logic [WW-1:0]     bar_wid;
    logic [BW-1:0]     bar_id;
    logic [WW-1:0]     bar_size_m1;
    logic [IW-1:0]     out_ready;
    logic [NW-1:0]     rr_active, fp_active;
    logic              rr_busy, fp_busy;
`ifdef SCHED_PERF_EN
    logic [IW*32-1:0]  rr_idles, rr_stalls, fp_idles, fp_stalls;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_warp_sched_mc_if #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PB), .ISSUE_WIDTH(IW)) rr_if ();
    vx_warp_sched_mc_if #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PB), .ISSUE_WIDTH(IW)) fp_if ();
    assign rr_if.out_ready = out_ready;
    assign fp_if.out_ready = out_ready;

    vx_warp_sched_mc #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PB), .ISSUE_WIDTH(IW),
                       .NUM_BARRIERS(NB), .RR_POLICY(1)) u_rr (
        .clk(clk), .reset(reset), .startup_pc(startup_pc),
        .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
        .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
        .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_mask(tmc_mask),
        .bar_valid(bar_valid), .bar_wid(bar_wid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
        .fetch(rr_if), .active_warps(rr_active), .busy(rr_busy)
`ifdef SCHED_PERF_EN
        , .perf_idles(rr_idles), .perf_stalls(rr_stalls)
`endif
    );

    vx_warp_sched_mc #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PB), .ISSUE_WIDTH(IW),
                       .NUM_BARRIERS(NB), .RR_POLICY(0)) u_fp (
        .clk(clk), .reset(reset), .startup_pc(startup_pc),
        .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
        .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
        .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_mask(tmc_mask),
        .bar_valid(bar_valid), .bar_wid(bar_wid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
        .fetch(fp_if), .active_warps(fp_active), .busy(fp_busy)
`ifdef SCHED_PERF_EN
        , .perf_idles(fp_idles), .perf_stalls(fp_stalls)
`endif
    );

    // Policy-comparison vectors: inputs for one cycle, then expected
    // channel-0 output of both instances after that cycle's edge.
    typedef struct packed {
        logic          ready;
        logic          unl_v;
        logic [WW-1:0] unl_wid;
        logic          tmc_v;
        logic [WW-1:0] tmc_w;
        logic [WW-1:0] rr_wid;
        logic [PB-1:0] rr_pc;
        logic [WW-1:0] fp_wid;
        logic [PB-1:0] fp_pc;
        logic [NW-1:0] act;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        unlock_valid = '0; unlock_wid = '0;
        br_valid = '0; br_wid = '0; br_taken = '0; br_dest = '0;
        tmc_valid = 1'b0; tmc_wid = '0; tmc_mask = '0;
        bar_valid = 1'b0; bar_wid = '0; bar_id = '0; bar_size_m1 = '0;
    endtask

    task automatic assert_reset(input logic [PB-1:0] spc, input logic [IW-1:0] rdy);
        idle_inputs();
        startup_pc = spc;
        out_ready  = rdy;
        reset      = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic barrier(input logic [WW-1:0] w, input logic [BW-1:0] id, input logic [WW-1:0] sm1);
        bar_valid = 1'b1; bar_wid = w; bar_id = id; bar_size_m1 = sm1;
        step();
        bar_valid = 1'b0;
    endtask

    initial begin
        //        rdy   unl  uwid  tmc  twid  rr_wid rr_pc      fp_wid fp_pc      active
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 3'd0, 30'h100, 3'd0, 30'h100, 8'h05};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 3'd0, 30'h100, 3'd0, 30'h100, 8'h15};
        vecs[2]  = '{1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 30'h100, 3'd0, 30'h100, 8'h15};
        vecs[3]  = '{1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 3'd0, 30'h100, 3'd0, 30'h100, 8'h15};
        vecs[4]  = '{1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 3'd0, 30'h100, 3'd0, 30'h100, 8'h15};
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2, 30'h000, 3'd0, 30'h101, 8'h15};
        vecs[6]  = '{1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd2, 30'h000, 3'd0, 30'h101, 8'h15};
        vecs[7]  = '{1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 3'd2, 30'h000, 3'd0, 30'h101, 8'h15};
        vecs[8]  = '{1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 3'd2, 30'h000, 3'd0, 30'h101, 8'h15};
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd4, 30'h000, 3'd0, 30'h102, 8'h15};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd4, 30'h000, 3'd0, 30'h102, 8'h15};
        vecs[11] = '{1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 3'd4, 30'h000, 3'd0, 30'h102, 8'h15};
        vecs[12] = '{1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 3'd4, 30'h000, 3'd0, 30'h102, 8'h15};
        vecs[13] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 30'h101, 3'd0, 30'h103, 8'h15};

        // ---------------- Boot, unlock, TMC deactivate -------------------
        assert_reset(30'h100, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(rr_if.out_valid), 64'h0);
        check("reset out_pc", 64'(rr_if.out_pc), 64'h0);
        check("reset active", 64'(rr_active), 64'h01);
        check("reset busy", 64'(rr_busy), 64'h0);
        check("reset fp out_valid", 64'(fp_if.out_valid), 64'h0);
        release_reset();

        step();
        check("boot out_valid", 64'(rr_if.out_valid), 64'h1);
        check("boot wid", 64'(rr_if.out_wid[2:0]), 64'h0);
        check("boot pc", 64'(rr_if.out_pc[29:0]), 64'h100);
        check("boot tmask", 64'(rr_if.out_tmask[3:0]), 64'h1);
        check("boot busy", 64'(rr_busy), 64'h1);
        step();
        check("drop after accept", 64'(rr_if.out_valid), 64'h0);
        step();
        check("no reissue while stalled", 64'(rr_if.out_valid), 64'h0);
        unlock_valid = 2'b01; unlock_wid = '0;
        step();
        unlock_valid = '0;
        check("unlock edge no issue", 64'(rr_if.out_valid), 64'h0);
        step();
        check("reissue valid", 64'(rr_if.out_valid), 64'h1);
        check("reissue pc", 64'(rr_if.out_pc[29:0]), 64'h101);
        tmc_valid = 1'b1; tmc_wid = 3'd0; tmc_mask = 4'h0;
        step();
        tmc_valid = 1'b0;
        check("tmc0 active", 64'(rr_active), 64'h0);
        check("tmc0 out_valid", 64'(rr_if.out_valid), 64'h0);
        check("tmc0 busy still high", 64'(rr_busy), 64'h1);
        step();
        check("busy falls", 64'(rr_busy), 64'h0);

        // ---------------- Round-robin vs fixed priority ------------------
        assert_reset(30'h100, 2'b00);
        release_reset();
        tmc_mask = 4'hF;
        for (int i = 0; i < 14; i++) begin
            out_ready    = {1'b1, vecs[i].ready};
            unlock_valid = {1'b0, vecs[i].unl_v};
            unlock_wid   = {3'd0, vecs[i].unl_wid};
            tmc_valid    = vecs[i].tmc_v;
            tmc_wid      = vecs[i].tmc_w;
            step();
            check($sformatf("vec%0d rr valid", i), 64'(rr_if.out_valid[0]), 64'h1);
            check($sformatf("vec%0d rr wid", i), 64'(rr_if.out_wid[2:0]), 64'(vecs[i].rr_wid));
            check($sformatf("vec%0d rr pc", i), 64'(rr_if.out_pc[29:0]), 64'(vecs[i].rr_pc));
            check($sformatf("vec%0d fp wid", i), 64'(fp_if.out_wid[2:0]), 64'(vecs[i].fp_wid));
            check($sformatf("vec%0d fp pc", i), 64'(fp_if.out_pc[29:0]), 64'(vecs[i].fp_pc));
            check($sformatf("vec%0d active", i), 64'(rr_active), 64'(vecs[i].act));
        end
        idle_inputs();

        // ---------------- Barriers on channel 1 --------------------------
        assert_reset(30'h100, 2'b11);
        release_reset();
        tmc_mask = 4'hF;
        tmc_valid = 1'b1; tmc_wid = 3'd1; step();
        tmc_wid = 3'd3; step();
        tmc_wid = 3'd5; step();
        tmc_valid = 1'b0;
        repeat (3) step();
        check("bar pre stalled", 64'(u_rr.stalled_q & 8'h2A), 64'h2A);
        barrier(3'd1, 2'd1, 3'd2);
        barrier(3'd3, 2'd1, 3'd2);
        check("bar cnt after two", 64'(u_rr.bar_cnt_q[1]), 64'h2);
        check("bar mask after two", 64'(u_rr.bar_mask_q[1]), 64'h0A);
        check("bar waiters stalled", 64'(u_rr.stalled_q & 8'h2A), 64'h2A);
        barrier(3'd5, 2'd1, 3'd2);
        check("bar release stalled", 64'(u_rr.stalled_q & 8'h2A), 64'h00);
        check("bar release cnt", 64'(u_rr.bar_cnt_q[1]), 64'h0);
        check("bar release mask", 64'(u_rr.bar_mask_q[1]), 64'h0);
        step();
        check("post-bar issue wid1", 64'(rr_if.out_wid[5:3]), 64'h1);
        check("post-bar issue pc1", 64'(rr_if.out_pc[59:30]), 64'h1);
        step();
        check("post-bar issue wid3", 64'(rr_if.out_wid[5:3]), 64'h3);
        step();
        check("post-bar issue wid5", 64'(rr_if.out_wid[5:3]), 64'h5);
        check("post-bar issue pc5", 64'(rr_if.out_pc[59:30]), 64'h1);
        step();
        check("ch1 drained", 64'(rr_if.out_valid[1]), 64'h0);
        barrier(3'd3, 2'd2, 3'd0);
        check("size0 release", 64'(u_rr.stalled_q[3]), 64'h0);
        check("size0 cnt", 64'(u_rr.bar_cnt_q[2]), 64'h0);
        step();
        check("size0 reissue wid", 64'(rr_if.out_wid[5:3]), 64'h3);
        check("size0 reissue pc", 64'(rr_if.out_pc[59:30]), 64'h2);
        barrier(3'd1, 2'd1, 3'd2);
        check("pending bar cnt", 64'(u_rr.bar_cnt_q[1]), 64'h1);

        // ---------------- Reset discards barrier; backpressure -----------
        assert_reset(30'h100, 2'b00);
        check("reset clears bar cnt", 64'(u_rr.bar_cnt_q[1]), 64'h0);
        check("reset clears bar mask", 64'(u_rr.bar_mask_q[1]), 64'h0);
        release_reset();
        step();
        check("bp first issue", 64'(rr_if.out_pc[29:0]), 64'h100);
        unlock_valid = 2'b01; unlock_wid = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            unlock_valid = '0;
            check($sformatf("bp%0d valid", i), 64'(rr_if.out_valid[0]), 64'h1);
            check($sformatf("bp%0d pc", i), 64'(rr_if.out_pc[29:0]), 64'h100);
            check($sformatf("bp%0d wid", i), 64'(rr_if.out_wid[2:0]), 64'h0);
            check($sformatf("bp%0d warp pc", i), 64'(u_rr.pc_q[0]), 64'h101);
        end
        out_ready = 2'b11;
        step();
        check("bp release valid", 64'(rr_if.out_valid[0]), 64'h1);
        check("bp release pc", 64'(rr_if.out_pc[29:0]), 64'h101);
`ifdef SCHED_PERF_EN
        check("perf_stalls ch0", 64'(rr_stalls[31:0]), 64'd5);
        check("perf_idles ch0", 64'(rr_idles[31:0]), 64'd1);
        check("perf_idles ch1", 64'(rr_idles[63:32]), 64'd7);
`endif

        // ---------------- Branch and PC wrap ------------------------------
        assert_reset(30'h3FFF_FFFF, 2'b11);
        release_reset();
        tmc_valid = 1'b1; tmc_wid = 3'd1; tmc_mask = 4'h3;
        step();
        tmc_valid = 1'b0;
        check("wrap issue pc", 64'(rr_if.out_pc[29:0]), 64'h3FFF_FFFF);
        check("wrap warp pc", 64'(u_rr.pc_q[0]), 64'h0);
        step();
        check("wid1 first valid", 64'(rr_if.out_valid[1]), 64'h1);
        check("wid1 first pc", 64'(rr_if.out_pc[59:30]), 64'h0);
        check("wid1 tmask", 64'(rr_if.out_tmask[7:4]), 64'h3);
        step();
        br_valid = 2'b10; br_wid = {3'd1, 3'd0}; br_taken = 2'b10; br_dest = {30'h40, 30'h0};
        unlock_valid = 2'b01; unlock_wid = '0;
        step();
        idle_inputs();
        check("branch edge no issue", 64'(rr_if.out_valid[1]), 64'h0);
        step();
        check("branch issue valid", 64'(rr_if.out_valid[1]), 64'h1);
        check("branch issue pc", 64'(rr_if.out_pc[59:30]), 64'h40);
        check("wrapped pc issued", 64'(rr_if.out_pc[29:0]), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
